// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module  : serial_subtractor_pkg
// Brief   : Shared FSM encoding and sizing helper for the bit-serial subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor4_full_subtractor.sv
// ============================================================================
// Module  : full_subtractor
// Brief   : Combinational single-bit subtractor cell: d = a - b - bin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor4.sv
// ============================================================================
// Module  : serial_subtractor4
// Brief   : Bit-serial ripple-borrow subtractor, LSB first, start/busy/done.
//           Define SERSUB_SIGNED_OVF_EN to add the signed-overflow output ovf.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor4
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             borrowin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERSUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             borrowout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int RES_W = WIDTH - 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               br_q, br_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrowout_q, borrowout_d;
    logic               cell_d, cell_bout;
    logic               last_bit;

    full_subtractor u_cell (
        .a    (x_q[0]),
        .b    (y_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        br_d        = br_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        borrowout_d = borrowout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    br_d    = borrowin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                br_d  = cell_bout;
                // Result fills from the MSB side; the final bit completes diff directly.
                res_d = RES_W'({cell_d, res_q} >> 1);
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    diff_d      = {cell_d, res_q};
                    borrowout_d = cell_bout;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            br_q        <= 1'b0;
            res_q       <= '0;
            cnt_q       <= '0;
            diff_q      <= '0;
            borrowout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            br_q        <= br_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            borrowout_q <= borrowout_d;
        end
    end

`ifdef SERSUB_SIGNED_OVF_EN
    // Operand sign bits are shifted out, so keep copies for the overflow test.
    logic xm_q, xm_d;
    logic ym_q, ym_d;
    logic ovf_q, ovf_d;

    always_comb begin
        xm_d  = xm_q;
        ym_d  = ym_q;
        ovf_d = ovf_q;
        if ((state_q == IDLE || state_q == DONE) && start) begin
            xm_d = x[WIDTH-1];
            ym_d = y[WIDTH-1];
        end else if (state_q == SHIFT && last_bit) begin
            ovf_d = (xm_q != ym_q) && (cell_d != xm_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xm_q  <= 1'b0;
            ym_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            xm_q  <= xm_d;
            ym_q  <= ym_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Unsigned-only build: no sign tracking is kept.
`endif

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign diff      = diff_q;
    assign borrowout = borrowout_q;

endmodule

`default_nettype wire
